// File: rtl/hint_evaluator.sv
// Sequential Mastermind hint scorer: latches guess/secret on start, counts exact
// matches in one pass and colour-only matches (single consumption) in a second.
module hint_evaluator #(
  parameter int MAX_PINS = 20,
  parameter int COLOR_W  = 5,
  parameter int POS_W    = 5
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        start,
  input  logic [POS_W-1:0]            pins_count,
  input  logic [MAX_PINS*COLOR_W-1:0] guess,
  input  logic [MAX_PINS*COLOR_W-1:0] secret,
  output logic                        busy,
  output logic                        done,
  output logic [POS_W-1:0]            green,
  output logic [POS_W-1:0]            yellow,
  output logic                        win
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_GREEN,
    S_YELLOW,
    S_DONE
  } state_t;

  state_t               r_state;
  state_t               w_state_nxt;
  logic [POS_W-1:0]     r_idx;
  logic [POS_W-1:0]     r_n;
  logic [COLOR_W-1:0]   r_guess  [MAX_PINS];
  logic [COLOR_W-1:0]   r_secret [MAX_PINS];
  logic [MAX_PINS-1:0]  r_gmark;
  logic [MAX_PINS-1:0]  r_smark;
  logic [POS_W-1:0]     r_green_cnt;
  logic [POS_W-1:0]     r_yellow_cnt;
  logic [POS_W-1:0]     r_green;
  logic [POS_W-1:0]     r_yellow;
  logic                 r_win;

  logic [POS_W-1:0]     w_n_clamped;
  logic                 w_last;
  logic                 w_pin_match;
  logic                 w_found;
  logic                 w_take;
  logic [MAX_PINS-1:0]  w_claim;
  logic [POS_W-1:0]     w_yellow_nxt;

  assign w_n_clamped  = (pins_count > POS_W'(MAX_PINS)) ? POS_W'(MAX_PINS) : pins_count;
  assign w_last       = (r_idx == (r_n - POS_W'(1)));
  assign w_pin_match  = (r_guess[r_idx] == r_secret[r_idx]);
  assign w_take       = !r_gmark[r_idx] && w_found;
  assign w_yellow_nxt = w_take ? (r_yellow_cnt + POS_W'(1)) : r_yellow_cnt;

  // Descending scan so the last hit recorded is the lowest free matching secret pin.
  always_comb begin
    w_found = 1'b0;
    w_claim = '0;
    for (int j = MAX_PINS - 1; j >= 0; j--) begin
      if ((POS_W'(j) < r_n) && !r_smark[j] && (r_secret[j] == r_guess[r_idx])) begin
        w_found    = 1'b1;
        w_claim    = '0;
        w_claim[j] = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:   if (start) w_state_nxt = (w_n_clamped != '0) ? S_GREEN : S_DONE;
      S_GREEN:  if (w_last) w_state_nxt = S_YELLOW;
      S_YELLOW: if (w_last) w_state_nxt = S_DONE;
      S_DONE:   w_state_nxt = S_IDLE;
      default:  w_state_nxt = S_IDLE;
    endcase
  end

  // Result registers are only written when entering DONE, so partial counts never escape.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_idx        <= '0;
      r_n          <= '0;
      r_gmark      <= '0;
      r_smark      <= '0;
      r_green_cnt  <= '0;
      r_yellow_cnt <= '0;
      r_green      <= '0;
      r_yellow     <= '0;
      r_win        <= 1'b0;
      for (int i = 0; i < MAX_PINS; i++) begin
        r_guess[i]  <= '0;
        r_secret[i] <= '0;
      end
    end else begin
      case (r_state)
        S_IDLE: begin
          if (start) begin
            for (int i = 0; i < MAX_PINS; i++) begin
              r_guess[i]  <= guess[i*COLOR_W +: COLOR_W];
              r_secret[i] <= secret[i*COLOR_W +: COLOR_W];
            end
            r_n          <= w_n_clamped;
            r_idx        <= '0;
            r_gmark      <= '0;
            r_smark      <= '0;
            r_green_cnt  <= '0;
            r_yellow_cnt <= '0;
            if (w_n_clamped == '0) begin
              r_green  <= '0;
              r_yellow <= '0;
              r_win    <= 1'b0;
            end
          end
        end
        S_GREEN: begin
          if (w_pin_match) begin
            r_gmark[r_idx] <= 1'b1;
            r_smark[r_idx] <= 1'b1;
            r_green_cnt    <= r_green_cnt + POS_W'(1);
          end
          r_idx <= w_last ? '0 : (r_idx + POS_W'(1));
        end
        S_YELLOW: begin
          if (w_take) begin
            r_smark      <= r_smark | w_claim;
            r_yellow_cnt <= w_yellow_nxt;
          end
          if (w_last) begin
            r_green  <= r_green_cnt;
            r_yellow <= w_yellow_nxt;
            r_win    <= (r_green_cnt == r_n) && (r_n != '0);
          end else begin
            r_idx <= r_idx + POS_W'(1);
          end
        end
        default: begin
        end
      endcase
    end
  end

  assign busy   = (r_state != S_IDLE);
  assign done   = (r_state == S_DONE);
  assign green  = r_green;
  assign yellow = r_yellow;
  assign win    = r_win;

endmodule
